// File: rtl/gray_pixel_packer.sv
// RGB-to-gray converter with programmable weights and output modes. It packs
// pixels into SDRAM words and buffers them in a small FIFO with valid/ready.
module gray_pixel_packer #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8,
    parameter int PACK  = 2,
    parameter int DEPTH = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iSOF,
    input  logic                       iEOL,
    input  logic                       iDVAL,
    input  logic [IN_W-1:0]            iR,
    input  logic [IN_W-1:0]            iG,
    input  logic [IN_W-1:0]            iB,
    input  logic [1:0]                 iMODE,
    input  logic [7:0]                 iCOEF_R,
    input  logic [7:0]                 iCOEF_G,
    input  logic [7:0]                 iCOEF_B,
    input  logic [OUT_W-1:0]           iTHRESH,
    input  logic                       iCLR_OVF,
    output logic [OUT_W*PACK-1:0]      oDATA,
    output logic                       oVALID,
    input  logic                       iREADY,
    output logic [$clog2(DEPTH+1)-1:0] oLEVEL,
    output logic                       oOVF,
    output logic [15:0]                oFRAME_CNT,
    output logic [15:0]                oLINE_CNT
);

    localparam int PROD_W = IN_W + 8;
    localparam int SUM_W  = IN_W + 10;
    localparam int WORD_W = OUT_W * PACK;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int MAX_IN = (1 << IN_W) - 1;

    localparam logic [1:0] MODE_GRAY   = 2'd0;
    localparam logic [1:0] MODE_PASS_R = 2'd1;
    localparam logic [1:0] MODE_PASS_G = 2'd2;
    localparam logic [1:0] MODE_THRESH = 2'd3;

    // Configuration shadow, only updated at frame boundaries
    logic [1:0]       cfg_mode;
    logic [7:0]       cfg_coef_r;
    logic [7:0]       cfg_coef_g;
    logic [7:0]       cfg_coef_b;
    logic [OUT_W-1:0] cfg_thresh;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cfg_mode   <= MODE_GRAY;
            cfg_coef_r <= 8'd27;
            cfg_coef_g <= 8'd91;
            cfg_coef_b <= 8'd9;
            cfg_thresh <= OUT_W'(128);
        end else if (iSOF) begin
            cfg_mode   <= iMODE;
            cfg_coef_r <= iCOEF_R;
            cfg_coef_g <= iCOEF_G;
            cfg_coef_b <= iCOEF_B;
            cfg_thresh <= iTHRESH;
        end
    end

    // Stage 1: weighted products
    logic              s1_valid;
    logic              s1_eol;
    logic [PROD_W-1:0] s1_pr;
    logic [PROD_W-1:0] s1_pg;
    logic [PROD_W-1:0] s1_pb;
    logic [OUT_W-1:0]  s1_r_top;
    logic [OUT_W-1:0]  s1_g_top;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_valid <= 1'b0;
            s1_eol   <= 1'b0;
            s1_pr    <= '0;
            s1_pg    <= '0;
            s1_pb    <= '0;
            s1_r_top <= '0;
            s1_g_top <= '0;
        end else begin
            s1_valid <= iDVAL & ~iSOF;
            s1_eol   <= iDVAL & iEOL;
            s1_pr    <= PROD_W'(iR) * PROD_W'(cfg_coef_r);
            s1_pg    <= PROD_W'(iG) * PROD_W'(cfg_coef_g);
            s1_pb    <= PROD_W'(iB) * PROD_W'(cfg_coef_b);
            s1_r_top <= iR[IN_W-1 -: OUT_W];
            s1_g_top <= iG[IN_W-1 -: OUT_W];
        end
    end

    // Stage 2: sum, scale by 1/128, saturate, keep the top OUT_W bits
    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] shifted_c;
    logic [OUT_W-1:0] gray_c;

    always_comb begin
        sum_c     = SUM_W'(s1_pr) + SUM_W'(s1_pg) + SUM_W'(s1_pb);
        shifted_c = sum_c >> 7;
        if (shifted_c > SUM_W'(MAX_IN)) begin
            gray_c = '1;
        end else begin
            gray_c = shifted_c[IN_W-1 -: OUT_W];
        end
    end

    logic             s2_valid;
    logic             s2_eol;
    logic [OUT_W-1:0] s2_gray;
    logic [OUT_W-1:0] s2_pass;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s2_valid <= 1'b0;
            s2_eol   <= 1'b0;
            s2_gray  <= '0;
            s2_pass  <= '0;
        end else begin
            s2_valid <= s1_valid & ~iSOF;
            s2_eol   <= s1_eol;
            s2_gray  <= gray_c;
            s2_pass  <= (cfg_mode == MODE_PASS_G) ? s1_g_top : s1_r_top;
        end
    end

    // Stage 3: output mode select
    logic [OUT_W-1:0] mode_pix_c;

    always_comb begin
        mode_pix_c = s2_gray;
        case (cfg_mode)
            MODE_GRAY:   mode_pix_c = s2_gray;
            MODE_PASS_R: mode_pix_c = s2_pass;
            MODE_PASS_G: mode_pix_c = s2_pass;
            MODE_THRESH: mode_pix_c = (s2_gray >= cfg_thresh) ? '1 : '0;
            default:     mode_pix_c = s2_gray;
        endcase
    end

    logic             s3_valid;
    logic             s3_eol;
    logic [OUT_W-1:0] s3_pix;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s3_valid <= 1'b0;
            s3_eol   <= 1'b0;
            s3_pix   <= '0;
        end else begin
            s3_valid <= s2_valid & ~iSOF;
            s3_eol   <= s2_eol;
            s3_pix   <= mode_pix_c;
        end
    end

    // Packer: the word handed to the FIFO already contains the current pixel
    logic [CNT_W-1:0]  pack_cnt;
    logic [WORD_W-1:0] pack_word;
    logic [WORD_W-1:0] word_merge;
    logic              push_req;

    always_comb begin
        word_merge = pack_word;
        word_merge[pack_cnt*OUT_W +: OUT_W] = s3_pix;
        push_req = s3_valid & ~iSOF &
                   ((pack_cnt == CNT_W'(PACK - 1)) | s3_eol);
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iSOF) begin
            pack_cnt  <= '0;
            pack_word <= '0;
        end else if (s3_valid) begin
            if (push_req) begin
                pack_cnt  <= '0;
                pack_word <= '0;
            end else begin
                pack_cnt  <= pack_cnt + CNT_W'(1);
                pack_word <= word_merge;
            end
        end
    end

    // Output FIFO, first-word fall-through
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              do_push;
    logic              do_pop;
    logic              ovf_set;

    always_comb begin
        fifo_full  = (fifo_cnt == LVL_W'(DEPTH));
        fifo_empty = (fifo_cnt == '0);
        do_pop     = iREADY & ~fifo_empty;
        // A pop on the same edge frees the slot a full-FIFO push needs
        do_push    = push_req & (~fifo_full | do_pop);
        ovf_set    = push_req & fifo_full & ~do_pop;
    end

    always_ff @(posedge iCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= word_merge;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + LVL_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - LVL_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oOVF <= 1'b0;
        end else if (ovf_set) begin
            oOVF <= 1'b1;
        end else if (iCLR_OVF) begin
            oOVF <= 1'b0;
        end
    end

    // Frame and line counters
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oFRAME_CNT <= '0;
            oLINE_CNT  <= '0;
        end else if (iSOF) begin
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
            oLINE_CNT  <= '0;
        end else if (iDVAL && iEOL) begin
            oLINE_CNT  <= oLINE_CNT + 16'd1;
        end
    end

    always_comb begin
        oVALID = ~fifo_empty;
        oLEVEL = fifo_cnt;
        oDATA  = fifo_empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Directed bench for gray_pixel_packer at default parameters
// (IN_W=12, OUT_W=8, PACK=2, DEPTH=4).
module tb_gray_pixel_packer;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSOF;
    logic        iEOL;
    logic        iDVAL;
    logic [11:0] iR;
    logic [11:0] iG;
    logic [11:0] iB;
    logic [1:0]  iMODE;
    logic [7:0]  iCOEF_R;
    logic [7:0]  iCOEF_G;
    logic [7:0]  iCOEF_B;
    logic [7:0]  iTHRESH;
    logic        iCLR_OVF;
    logic [15:0] oDATA;
    logic        oVALID;
    logic        iREADY;
    logic [2:0]  oLEVEL;
    logic        oOVF;
    logic [15:0] oFRAME_CNT;
    logic [15:0] oLINE_CNT;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_frame = 16'd0;

    always #5 iCLK = ~iCLK;

    gray_pixel_packer dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSOF       (iSOF),
        .iEOL       (iEOL),
        .iDVAL      (iDVAL),
        .iR         (iR),
        .iG         (iG),
        .iB         (iB),
        .iMODE      (iMODE),
        .iCOEF_R    (iCOEF_R),
        .iCOEF_G    (iCOEF_G),
        .iCOEF_B    (iCOEF_B),
        .iTHRESH    (iTHRESH),
        .iCLR_OVF   (iCLR_OVF),
        .oDATA      (oDATA),
        .oVALID     (oVALID),
        .iREADY     (iREADY),
        .oLEVEL     (oLEVEL),
        .oOVF       (oOVF),
        .oFRAME_CNT (oFRAME_CNT),
        .oLINE_CNT  (oLINE_CNT)
    );

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input logic [11:0] r, input logic [11:0] g,
                       input logic [11:0] b, input logic eol);
        iDVAL = 1'b1;
        iR    = r;
        iG    = g;
        iB    = b;
        iEOL  = eol;
        tick();
        iDVAL = 1'b0;
        iEOL  = 1'b0;
    endtask

    task automatic sof();
        iSOF = 1'b1;
        tick();
        iSOF = 1'b0;
        exp_frame = exp_frame + 16'd1;
    endtask

    task automatic pop();
        iREADY = 1'b1;
        tick();
        iREADY = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] cr,
                           input logic [7:0] cg, input logic [7:0] cb,
                           input logic [7:0] th);
        iMODE   = m;
        iCOEF_R = cr;
        iCOEF_G = cg;
        iCOEF_B = cb;
        iTHRESH = th;
    endtask

    task automatic test_reset();
        iRST  = 1'b1;
        iDVAL = 1'b1;
        iR = 12'hFFF; iG = 12'hFFF; iB = 12'hFFF;
        tick();
        iDVAL = 1'b0;
        iSOF  = 1'b1;
        tick();
        iDVAL = 1'b1;
        iSOF  = 1'b0;
        iRST  = 1'b0;
        checks++;
        if (oDATA !== 16'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=%h", oDATA, 16'h0);
        end
        checks++;
        if (oVALID !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", oVALID);
        end
        checks++;
        if (oLEVEL !== 3'd0) begin
            failures++; $display("FAIL reset_level got=%0d exp=0", oLEVEL);
        end
        checks++;
        if (oOVF !== 1'b0) begin
            failures++; $display("FAIL reset_ovf got=%b exp=0", oOVF);
        end
        checks++;
        if (oFRAME_CNT !== 16'd0) begin
            failures++; $display("FAIL reset_frame got=%h exp=0", oFRAME_CNT);
        end
        checks++;
        if (oLINE_CNT !== 16'd0) begin
            failures++; $display("FAIL reset_line got=%h exp=0", oLINE_CNT);
        end
        iDVAL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (oVALID !== 1'b0 || oLEVEL !== 3'd0) begin
                failures++;
                $display("FAIL reset_no_push cycle=%0d got valid=%b level=%0d exp 0/0",
                         i, oVALID, oLEVEL);
            end
        end
    endtask

    task automatic test_default_weights();
        set_cfg(2'd0, 8'd27, 8'd91, 8'd9, 8'h80);
        sof();
        pix(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
        pix(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
        idle(2);
        checks++;
        if (oVALID !== 1'b0) begin
            failures++; $display("FAIL default_early_valid got=%b exp=0", oVALID);
        end
        idle(1);
        checks++;
        if (oVALID !== 1'b1) begin
            failures++; $display("FAIL default_valid got=%b exp=1", oVALID);
        end
        checks++;
        if (oDATA !== 16'hFDFD) begin
            failures++; $display("FAIL default_data got=%h exp=%h", oDATA, 16'hFDFD);
        end
        checks++;
        if (oLEVEL !== 3'd1) begin
            failures++; $display("FAIL default_level got=%0d exp=1", oLEVEL);
        end
        pop();
        checks++;
        if (oLEVEL !== 3'd0 || oVALID !== 1'b0) begin
            failures++;
            $display("FAIL default_pop got level=%0d valid=%b exp 0/0", oLEVEL, oVALID);
        end
    endtask

    task automatic test_saturation();
        set_cfg(2'd0, 8'd255, 8'd255, 8'd255, 8'h80);
        sof();
        pix(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
        pix(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
        idle(3);
        checks++;
        if (oDATA !== 16'hFFFF) begin
            failures++; $display("FAIL saturation_data got=%h exp=%h", oDATA, 16'hFFFF);
        end
        pop();
    endtask

    task automatic test_modes();
        set_cfg(2'd3, 8'd128, 8'd0, 8'd0, 8'h80);
        sof();
        pix(12'h7FF, 12'hFFF, 12'hFFF, 1'b0);
        pix(12'h80F, 12'h000, 12'h000, 1'b0);
        idle(3);
        checks++;
        if (oDATA !== 16'hFF00) begin
            failures++; $display("FAIL thresh_data got=%h exp=%h", oDATA, 16'hFF00);
        end
        pop();
        set_cfg(2'd1, 8'd27, 8'd91, 8'd9, 8'h80);
        sof();
        pix(12'hAB5, 12'h5A7, 12'h111, 1'b0);
        pix(12'h3C0, 12'h0F0, 12'h222, 1'b0);
        idle(3);
        checks++;
        if (oDATA !== 16'h3CAB) begin
            failures++; $display("FAIL pass_r_data got=%h exp=%h", oDATA, 16'h3CAB);
        end
        pop();
        set_cfg(2'd2, 8'd27, 8'd91, 8'd9, 8'h80);
        sof();
        pix(12'hAB5, 12'h5A7, 12'h111, 1'b0);
        pix(12'h3C0, 12'h0F0, 12'h222, 1'b0);
        idle(3);
        checks++;
        if (oDATA !== 16'h0F5A) begin
            failures++; $display("FAIL pass_g_data got=%h exp=%h", oDATA, 16'h0F5A);
        end
        pop();
    endtask

    task automatic test_pack_eol();
        set_cfg(2'd0, 8'd128, 8'd0, 8'd0, 8'h80);
        sof();
        pix(12'h120, 12'h0, 12'h0, 1'b0);
        pix(12'h340, 12'h0, 12'h0, 1'b0);
        pix(12'h560, 12'h0, 12'h0, 1'b1);
        checks++;
        if (oLINE_CNT !== 16'd1) begin
            failures++; $display("FAIL eol_line_cnt got=%0d exp=1", oLINE_CNT);
        end
        idle(3);
        checks++;
        if (oLEVEL !== 3'd2) begin
            failures++; $display("FAIL eol_level got=%0d exp=2", oLEVEL);
        end
        checks++;
        if (oDATA !== 16'h3412) begin
            failures++; $display("FAIL eol_word0 got=%h exp=%h", oDATA, 16'h3412);
        end
        pop();
        checks++;
        if (oDATA !== 16'h0056) begin
            failures++; $display("FAIL eol_partial got=%h exp=%h", oDATA, 16'h0056);
        end
        pop();
        checks++;
        if (oFRAME_CNT !== exp_frame) begin
            failures++; $display("FAIL eol_frame got=%0d exp=%0d", oFRAME_CNT, exp_frame);
        end
    endtask

    task automatic test_back_to_back();
        iREADY = 1'b0;
        sof();
        for (int i = 1; i <= 10; i++) begin
            pix(12'(i * 16), 12'h0, 12'h0, 1'b0);
        end
        idle(3);
        checks++;
        if (oLEVEL !== 3'd4) begin
            failures++; $display("FAIL full_level got=%0d exp=4", oLEVEL);
        end
        checks++;
        if (oOVF !== 1'b1) begin
            failures++; $display("FAIL full_ovf got=%b exp=1", oOVF);
        end
        checks++;
        if (oDATA !== 16'h0201) begin
            failures++; $display("FAIL full_head got=%h exp=%h", oDATA, 16'h0201);
        end
        iCLR_OVF = 1'b1;
        tick();
        iCLR_OVF = 1'b0;
        checks++;
        if (oOVF !== 1'b0) begin
            failures++; $display("FAIL clr_ovf got=%b exp=0", oOVF);
        end
        pix(12'h0B0, 12'h0, 12'h0, 1'b0);
        pix(12'h0C0, 12'h0, 12'h0, 1'b0);
        idle(2);
        pop();
        checks++;
        if (oLEVEL !== 3'd4 || oOVF !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_full got level=%0d ovf=%b exp 4/0", oLEVEL, oOVF);
        end
        checks++;
        if (oDATA !== 16'h0403) begin
            failures++; $display("FAIL push_pop_head got=%h exp=%h", oDATA, 16'h0403);
        end
        pop(); pop(); pop();
        checks++;
        if (oDATA !== 16'h0C0B) begin
            failures++; $display("FAIL push_pop_tail got=%h exp=%h", oDATA, 16'h0C0B);
        end
        pop();
        pop();
        checks++;
        if (oLEVEL !== 3'd0 || oVALID !== 1'b0) begin
            failures++;
            $display("FAIL pop_empty got level=%0d valid=%b exp 0/0", oLEVEL, oVALID);
        end
    endtask

    task automatic test_config_latch();
        set_cfg(2'd0, 8'd0, 8'd128, 8'd0, 8'h80);
        sof();
        iCOEF_G = 8'd64;
        pix(12'h0, 12'h800, 12'h0, 1'b0);
        pix(12'h0, 12'h800, 12'h0, 1'b0);
        idle(3);
        checks++;
        if (oDATA !== 16'h8080) begin
            failures++; $display("FAIL cfg_midframe got=%h exp=%h", oDATA, 16'h8080);
        end
        pop();
        sof();
        pix(12'h0, 12'h800, 12'h0, 1'b0);
        pix(12'h0, 12'h800, 12'h0, 1'b0);
        idle(3);
        checks++;
        if (oDATA !== 16'h4040) begin
            failures++; $display("FAIL cfg_next_frame got=%h exp=%h", oDATA, 16'h4040);
        end
        pop();
    endtask

    task automatic test_sof_flush();
        set_cfg(2'd0, 8'd128, 8'd0, 8'd0, 8'h80);
        sof();
        pix(12'h110, 12'h0, 12'h0, 1'b0);
        sof();
        idle(4);
        checks++;
        if (oLEVEL !== 3'd0) begin
            failures++; $display("FAIL flush_pipe got=%0d exp=0", oLEVEL);
        end
        checks++;
        if (oFRAME_CNT !== exp_frame) begin
            failures++; $display("FAIL flush_frame got=%0d exp=%0d", oFRAME_CNT, exp_frame);
        end
        pix(12'h220, 12'h0, 12'h0, 1'b0);
        idle(4);
        sof();
        pix(12'h330, 12'h0, 12'h0, 1'b0);
        pix(12'h440, 12'h0, 12'h0, 1'b0);
        idle(3);
        checks++;
        if (oLEVEL !== 3'd1 || oDATA !== 16'h4433) begin
            failures++;
            $display("FAIL flush_lane got level=%0d data=%h exp 1/4433", oLEVEL, oDATA);
        end
        pop();
    endtask

    task automatic test_frame_wrap();
        int n;
        n = 32'hFFFF - int'(exp_frame);
        iSOF = 1'b1;
        repeat (n) tick();
        iSOF = 1'b0;
        exp_frame = 16'hFFFF;
        checks++;
        if (oFRAME_CNT !== exp_frame) begin
            failures++; $display("FAIL frame_max got=%h exp=%h", oFRAME_CNT, exp_frame);
        end
        sof();
        checks++;
        if (oFRAME_CNT !== 16'h0000 || oLINE_CNT !== 16'h0000) begin
            failures++;
            $display("FAIL frame_wrap got frame=%h line=%h exp 0000/0000",
                     oFRAME_CNT, oLINE_CNT);
        end
    endtask

    initial begin
        iRST = 1'b1; iSOF = 1'b0; iEOL = 1'b0; iDVAL = 1'b0;
        iR = '0; iG = '0; iB = '0;
        iMODE = 2'd0; iCOEF_R = 8'd27; iCOEF_G = 8'd91; iCOEF_B = 8'd9;
        iTHRESH = 8'h80; iCLR_OVF = 1'b0; iREADY = 1'b0;
        test_reset();
        test_default_weights();
        test_saturation();
        test_modes();
        test_pack_eol();
        test_back_to_back();
        test_config_latch();
        test_sof_flush();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_pixel_packer.md
# gray_pixel_packer

Parametrised RGB-to-grayscale converter and pixel packer between RAW2RGB (camera pixel clock domain) and the Sdram_Control_4Port write FIFOs. Replaces the fixed 27/91/9 inline grayscale path with:
- programmable weights;
- selectable output modes (weighted gray, single channel, binary threshold);
- packing of PACK pixels into one SDRAM word;
- a small output FIFO with valid/ready handshake, level and sticky overflow reporting;
- frame and line counters readable by the HPS.

## Interface
Parameters:
- IN_W, 12, bits per input colour channel
- OUT_W, 8, bits per output pixel (OUT_W <= IN_W)
- PACK, 2, pixels per output word (1..4)
- DEPTH, 4, output FIFO depth in words (power of 2, >= 2)

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iSOF  in  1  start-of-frame pulse, one cycle, never coincident with iDVAL
- iEOL  in  1  end-of-line tag, valid only with iDVAL on last pixel of line
- iDVAL  in  1  input pixel valid; no backpressure, camera never stalls
- iR, iG, iB  in  IN_W each  colour channels
- iMODE  in  2  0 weighted gray, 1 pass R, 2 pass G, 3 threshold
- iCOEF_R, iCOEF_G, iCOEF_B  in  8 each  unsigned weights, scale 1/128
- iTHRESH  in  OUT_W  threshold for mode 3
- iCLR_OVF  in  1  clears oOVF
- oDATA  out  OUT_W*PACK  packed word; pixel 0 in LSBs
- oVALID  out  1  FIFO non-empty
- iREADY  in  1  consumer pops head word when oVALID & iREADY
- oLEVEL  out  clog2(DEPTH+1)  words held in FIFO
- oOVF  out  1  sticky: a word was dropped because the FIFO was full
- oFRAME_CNT  out  16  frames started, wraps 0xFFFF -> 0
- oLINE_CNT  out  16  iEOL count in current frame, wraps

## Operation
- Config registers (mode, coefficients, threshold) latch on iSOF and on reset. Mid-frame input changes are ignored until the next iSOF. Reset values: mode 0, coefs 27/91/9, threshold 0x80.
- Stage 1: per-channel products ch*coef, each IN_W+8 bits; valid and eol tags carried along.
- Stage 2: sum (IN_W+10 bits), shift right by 7, clamp to 2^IN_W-1. Pixel = clamped[IN_W-1 -: OUT_W].
- Stage 2 in modes 1/2: pixel = iR/iG top OUT_W bits, taken unweighted.
- Stage 3 mode select. Mode 3: pixel = (weighted pixel >= iTHRESH) ? all ones : 0.
- Packer:
  - lane counter 0..PACK-1; each stage-3 valid pixel writes lane[cnt].
  - Word is pushed when cnt = PACK-1, or when the pixel carries eol (partial word: unfilled lanes zero).
  - Lane counter and lane register clear after each push.
- FIFO push/pop rules:
  - push when full and no pop: word dropped, oOVF <= 1.
  - simultaneous push and pop when full: both performed, no overflow.
  - pop when empty: ignored.
- oOVF clears on iCLR_OVF; a coincident overflow wins (oOVF stays 1).
- iSOF effects:
  - clears pipeline valid bits, lane counter and lane register;
  - clears oLINE_CNT and increments oFRAME_CNT;
  - FIFO contents are kept.
- iEOL increments oLINE_CNT at the same edge iDVAL samples it.

## Timing
- Reset: oDATA 0, oVALID 0, oLEVEL 0, oOVF 0, oFRAME_CNT 0, oLINE_CNT 0; pipeline and FIFO empty; lanes zero.
- Pixel latency: pixel sampled at edge E0 reaches its lane at E3.
- Completing pixel: if it fills the word, the word is written to the FIFO at E3; oVALID, oDATA and oLEVEL reflect it immediately after E3 (first-word fall-through).
- Throughput: one pixel per cycle sustained; one word per PACK cycles.
- oLEVEL updates on the same edge as the push/pop that changes it.
- iRST mid-frame overrides everything on that edge, including a coincident iSOF or push.
- iSOF with pixels in stages 1-3: those pixels are discarded; no partial word is emitted.

## Test plan
- Reset: assert iRST 2 cycles with iDVAL toggling -> all outputs 0, no push for 3 cycles after release.
- Default weights, PACK=2: R=G=B=0xFFF twice -> oDATA 0xFDFD (4095*127>>7=4063=0xFDF), oVALID rises 3 cycles after second pixel.
- Saturation and modes: coefs 255/255/255 after iSOF, R=G=B=0xFFF -> pixel 0xFF. Mode 3, iTHRESH 0x80, gray 0x7F -> 0x00; gray 0x80 -> 0xFF.
- Packing and eol, PACK=2: pixels 0x12, 0x34, 0x56 with iEOL on the third -> words 0x3412 then 0x0056; oLINE_CNT=1.
- Backpressure, DEPTH=4, iREADY=0: push 5 words -> oLEVEL 4, oOVF 1, head 1st word. iCLR_OVF -> oOVF 0. Pop with a coincident push at full -> oLEVEL stays 4, oOVF stays 0.
- Config latch / iSOF flush: change iCOEF_G mid-frame -> output unchanged until next iSOF. iSOF one cycle after a pixel -> no word from that pixel; oFRAME_CNT +1; 0xFFFF wraps to 0.
